// File: rtl/poly_mult_tile_sched.sv
// poly_mult_tile_sched: walks every A/B tile pair through poly_mult_top, one product in flight, tagging results with their offset
// Ports: clk/rst (sync, active high); start_i/abort_i job control; busy_o/done_o status;
//        a_tile_idx_o/b_tile_idx_o/tile_valid_o/tile_ready_i issue handshake to the multiplier;
//        mult_valid_i/sink_ready_i result side; res_valid_o/res_offset_o/res_last_o tagged result transfer.
module poly_mult_tile_sched #(
    parameter int DEGREE_N = 16,
    parameter int TILE_N   = 4,
    localparam int NT      = DEGREE_N / TILE_N,
    localparam int IDX_W   = (NT > 1) ? $clog2(NT) : 1,
    localparam int OFF_W   = $clog2(2 * DEGREE_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] a_tile_idx_o,
    output logic [IDX_W-1:0] b_tile_idx_o,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    input  logic             mult_valid_i,
    input  logic             sink_ready_i,
    output logic             res_valid_o,
    output logic [OFF_W-1:0] res_offset_o,
    output logic             res_last_o
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;
    state_t           r_state;
    logic [IDX_W-1:0] r_a, r_b;
    logic [OFF_W-1:0] r_off;
    logic             r_last;
    logic             w_xfer, w_a_end, w_b_end;
    assign w_a_end = r_a == IDX_W'(NT - 1);
    assign w_b_end = r_b == IDX_W'(NT - 1);
    // DRAIN only exists because mult_valid_i was seen, and the multiplier holds its result there
    assign w_xfer = !rst && !abort_i && sink_ready_i &&
                    ((r_state == S_WAIT && mult_valid_i) || r_state == S_DRAIN);
    assign busy_o       = r_state != S_IDLE;
    assign done_o       = r_state == S_DONE && !abort_i;
    assign tile_valid_o = r_state == S_ISSUE;
    assign res_valid_o  = w_xfer;
    assign res_last_o   = w_xfer && r_last;
    assign res_offset_o = r_off;
    assign a_tile_idx_o = r_a;
    assign b_tile_idx_o = r_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_off   <= '0;
            r_last  <= 1'b0;
        end else if (abort_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_state <= S_ISSUE;
                    r_a     <= '0;
                    r_b     <= '0;
                end
                S_ISSUE: if (tile_ready_i) begin
                    r_state <= S_WAIT;
                    r_off   <= (OFF_W'(r_a) + OFF_W'(r_b)) * OFF_W'(TILE_N);
                    r_last  <= w_a_end && w_b_end;
                end
                S_WAIT, S_DRAIN: if (w_xfer) begin
                    r_state <= r_last ? S_DONE : S_ISSUE;
                    if (!r_last) begin
                        r_b <= w_b_end ? '0 : r_b + IDX_W'(1);
                        if (w_b_end) r_a <= r_a + IDX_W'(1);
                    end
                end else if (r_state == S_WAIT && mult_valid_i) begin
                    r_state <= S_DRAIN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/poly_mult_tile_sched.md
Name: poly_mult_tile_sched

Overview:
Controller that sequences `poly_mult_top` through every tile pair of two DEGREE_N-coefficient polynomials.
- Issues A/B tile indices in row-major order (a outer, b inner) and gates the multiplier's `inputs_ready_signal`.
- Allows exactly one tile product in flight.
- Tags each returned partial-product tile with its coefficient base offset so downstream accumulation/FIFO logic can place it.
- Sits between the coefficient tile stores and `poly_mult_top`, ahead of the multi-output FIFO and `poly_mod`.

Parameters:
- DEGREE_N, 16, coefficients per polynomial; must be a multiple of TILE_N.
- TILE_N, 4, coefficients per tile.
- NT (localparam), DEGREE_N/TILE_N, tiles per polynomial.
- IDX_W (localparam), max(1,$clog2(NT)), tile index width.
- OFF_W (localparam), $clog2(2*DEGREE_N), result offset width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  begin a full multiplication; sampled only in IDLE
- abort_i  in  1  abandon current job; return to IDLE
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse after last tile result accepted
- a_tile_idx_o  out  IDX_W  A tile index of current issue
- b_tile_idx_o  out  IDX_W  B tile index of current issue
- tile_valid_o  out  1  drives multiplier `inputs_ready_signal`
- tile_ready_i  in  1  multiplier accepts tile pair when high with tile_valid_o
- mult_valid_i  in  1  multiplier `outputs_ready_signal`
- sink_ready_i  in  1  downstream FIFO can take a full result tile (2*TILE_N-1 coeffs)
- res_valid_o  out  1  result tile transfer this cycle
- res_offset_o  out  OFF_W  (a_idx+b_idx)*TILE_N of the result tile
- res_last_o  out  1  qualifies res_valid_o for final pair (NT-1,NT-1)

Behaviour:
- Reset (rst=1 at clk edge) forces IDLE.
  - Counters a_idx=b_idx=0.
  - Outputs: busy_o=0, done_o=0, tile_valid_o=0, res_valid_o=0, res_last_o=0, res_offset_o=0, a/b_tile_idx_o=0.
  - Reset mid-job discards all state; a late mult_valid_i is ignored.
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE:
  - start_i=1 -> ISSUE; a_idx=b_idx=0.
  - Otherwise hold.
- ISSUE:
  - tile_valid_o=1 (combinational from state). Indices held stable until handshake.
  - tile_ready_i=1 -> WAIT. Latch pair offset (a_idx+b_idx)*TILE_N and last flag (a_idx==NT-1 && b_idx==NT-1).
- WAIT:
  - tile_valid_o=0.
  - mult_valid_i=1 and sink_ready_i=1 -> transfer: res_valid_o=1 that cycle with latched offset/last.
    - Not last -> ISSUE and advance indices: b_idx+1; on b_idx wrap NT-1->0, a_idx+1.
    - Last -> DONE.
  - mult_valid_i=1 and sink_ready_i=0 -> DRAIN (result held by multiplier; no transfer).
- DRAIN:
  - Wait for sink_ready_i=1, then transfer exactly as WAIT.
  - Multiplier is required to hold outputs until accepted.
- DONE: done_o=1 for one cycle -> IDLE.
- Latency (sink always ready): zero-cycle issue, one cycle from result to next issue. Job of NT² pairs completes in sum over pairs of (1 + multiplier latency + 1) cycles, plus 1 for DONE.
- Offsets: range 0..2*(NT-1)*TILE_N, always < 2*DEGREE_N. Computed in OFF_W bits, no overflow.
- start_i while busy: ignored.
- abort_i:
  - Highest priority after rst; any non-IDLE state -> IDLE next cycle.
  - No done_o pulse, no res_valid_o that cycle.
- Simultaneous start_i and abort_i in IDLE: abort wins, stay IDLE.
- mult_valid_i outside WAIT/DRAIN: ignored, never produces res_valid_o.
- NT=1: single pair (0,0), offset 0, res_last_o=1 on its only result.

Test Plan:
1. DEGREE_N=8, TILE_N=4, start_i pulse; multiplier acks immediately and returns result 3 cycles after accept; sink_ready_i=1 -> pairs (0,0),(0,1),(1,0),(1,1); res_offset_o=0,4,4,8; res_last_o only on 4th; done_o one cycle after 4th res_valid_o; busy_o falls with done_o.
2. Same config, tile_ready_i held low 5 cycles on pair (0,1) -> tile_valid_o stays high, a/b_tile_idx_o stable at 0/1 all 5 cycles, issue proceeds on 6th.
3. sink_ready_i=0 when mult_valid_i arrives on pair (1,0) for 4 cycles -> state DRAIN, no res_valid_o; on sink_ready_i=1, one res_valid_o with offset 4, then pair (1,1) issues.
4. abort_i asserted in WAIT of pair (0,1) -> next cycle busy_o=0, no done_o; later mult_valid_i pulse yields no res_valid_o; new start_i restarts at (0,0).
5. rst asserted during ISSUE -> all outputs at reset values next cycle; start_i together with abort_i in IDLE -> remains IDLE; start_i while busy -> no restart, index sequence unchanged.
6. DEGREE_N=TILE_N=4 (NT=1) -> one issue at (0,0), res_offset_o=0, res_last_o=1, done_o follows.
